// File: rtl/dcache_pkg.sv
// Shared types and address-field widths for the direct-mapped data cache.
package dcache_pkg;

    localparam int ADDR_W   = 8;
    localparam int TAG_W    = 3;
    localparam int INDEX_W  = 3;
    localparam int OFFSET_W = 2;
    localparam int BLOCK_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        UPDATE
    } dcache_state_t;

endpackage

// File: rtl/dcache_line_store.sv
// Data, tag, valid and dirty storage for the data cache: one byte-write port,
// one whole-block fill port, and a synchronous invalidate-all on RESET.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int NUM_LINES   = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [$clog2(NUM_LINES)-1:0]   index,
    input  logic [$clog2(BLOCK_BYTES)-1:0] offset,
    input  logic                           byte_we,
    input  logic [7:0]                     byte_data,
    input  logic                           fill_en,
    input  logic [TAG_W-1:0]               fill_tag,
    input  logic [8*BLOCK_BYTES-1:0]       fill_data,
    output logic                           line_valid,
    output logic                           line_dirty,
    output logic [TAG_W-1:0]               line_tag,
    output logic [8*BLOCK_BYTES-1:0]       line_data
);

    logic [NUM_LINES-1:0]     valid_q;
    logic [NUM_LINES-1:0]     dirty_q;
    logic [TAG_W-1:0]         tag_q  [NUM_LINES];
    logic [8*BLOCK_BYTES-1:0] data_q [NUM_LINES];

    // Only the status bits are reset; tag and data contents are meaningless while invalid.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (byte_we) begin
            dirty_q[index] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tag_q[index]  <= fill_tag;
            data_q[index] <= fill_data;
        end else if (byte_we) begin
            data_q[index][{offset, 3'b000} +: 8] <= byte_data;
        end
    end

    assign line_valid = valid_q[index];
    assign line_dirty = dirty_q[index];
    assign line_tag   = tag_q[index];
    assign line_data  = data_q[index];

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller with miss FSM.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   IDLE      | serving hits combinationally; a miss leaves on the next edge
//   WRITEBACK | dirty victim line being written to memory
//   FETCH     | requested block being read from memory
//   UPDATE    | fetched block, tag and valid installed; line marked clean
module data_cache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES   = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       READ,
    input  logic                       WRITE,
    input  logic [ADDR_W-1:0]          ADDRESS,
    input  logic [7:0]                 WRITEDATA,
    output logic [7:0]                 READDATA,
    output logic                       BUSYWAIT,
    output logic                       MEM_READ,
    output logic                       MEM_WRITE,
    output logic [TAG_W+INDEX_W-1:0]   MEM_ADDRESS,
    output logic [8*BLOCK_BYTES-1:0]   MEM_WRITEDATA,
    input  logic [8*BLOCK_BYTES-1:0]   MEM_READDATA,
    input  logic                       MEM_BUSYWAIT
);

    localparam int BW = 8 * BLOCK_BYTES;

    dcache_state_t state, state_next;
    logic          in_state_q;

    logic [TAG_W-1:0]    addr_tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;

    logic          line_valid, line_dirty;
    logic [TAG_W-1:0] line_tag;
    logic [BW-1:0] line_data;

    logic idle, req, hit, mem_done, byte_we, fill_en;

    logic                     mem_read_q, mem_write_q;
    logic [TAG_W+INDEX_W-1:0] mem_addr_q;
    logic [BW-1:0]            mem_wdata_q;

    assign addr_tag = ADDRESS[ADDR_W-1 -: TAG_W];
    assign index    = ADDRESS[OFFSET_W +: INDEX_W];
    assign offset   = ADDRESS[OFFSET_W-1:0];

    dcache_line_store #(
        .NUM_LINES   (NUM_LINES),
        .BLOCK_BYTES (BLOCK_BYTES)
    ) u_line_store (
        .CLK        (CLK),
        .RESET      (RESET),
        .index      (index),
        .offset     (offset),
        .byte_we    (byte_we),
        .byte_data  (WRITEDATA),
        .fill_en    (fill_en),
        .fill_tag   (addr_tag),
        .fill_data  (MEM_READDATA),
        .line_valid (line_valid),
        .line_dirty (line_dirty),
        .line_tag   (line_tag),
        .line_data  (line_data)
    );

    assign idle = (state == IDLE);
    assign req  = READ || WRITE;
    assign hit  = line_valid && (line_tag == addr_tag);

    // The memory only raises its busy flag a cycle after seeing a request, so
    // its first-cycle "not busy" must not be taken as completion.
    assign mem_done = in_state_q && !MEM_BUSYWAIT;

    assign byte_we  = idle && WRITE && !READ && hit;
    assign fill_en  = (state == UPDATE);
    assign BUSYWAIT = !idle || (req && !hit);
    assign READDATA = (idle && READ && hit) ? line_data[{offset, 3'b000} +: 8] : 8'h00;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            in_state_q <= 1'b0;
        end else begin
            state      <= state_next;
            in_state_q <= (state_next == state);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (req && !hit) state_next = (line_valid && line_dirty) ? WRITEBACK : FETCH;
            WRITEBACK: if (mem_done) state_next = FETCH;
            FETCH:     if (mem_done) state_next = UPDATE;
            UPDATE:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Memory-side outputs are registered from the next state so they never
    // follow CPU-side inputs combinationally.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_read_q  <= (state_next == FETCH);
            mem_write_q <= (state_next == WRITEBACK);
            if (state_next == WRITEBACK) begin
                mem_addr_q <= {line_tag, index};
            end else if (state_next == FETCH) begin
                mem_addr_q <= {addr_tag, index};
            end else begin
                mem_addr_q <= '0;
            end
            mem_wdata_q <= (state_next == WRITEBACK) ? line_data : '0;
        end
    end

    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDRESS   = mem_addr_q;
    assign MEM_WRITEDATA = mem_wdata_q;

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    // The IDLE cycle right after UPDATE finishes a miss and is not a hit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (idle && in_state_q && req && hit && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (idle && req && !hit && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed, table-driven bench for data_cache_ctrl with a small latency-programmable memory model.
module tb_data_cache_ctrl;

    logic        CLK;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    data_cache_ctrl dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: a request occupies k = 1.. cycles; busy is raised from
    // cycle 2 through cycle mem_lat, so each transaction lasts mem_lat+1 cycles.
    int          mem_lat = 1;
    int          k = 0;
    logic        last_rd = 1'b0;
    logic        last_wr = 1'b0;
    logic        wb_seen = 1'b0;
    logic        rd_seen = 1'b0;
    logic [5:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [5:0]  rd_addr = '0;

    initial begin
        MEM_BUSYWAIT = 1'b0;
        forever begin
            @(negedge CLK);
            if (!(MEM_READ || MEM_WRITE)) k = 0;
            else if (k > 0 && MEM_READ == last_rd && MEM_WRITE == last_wr) k++;
            else k = 1;
            last_rd = MEM_READ;
            last_wr = MEM_WRITE;
            MEM_BUSYWAIT = (k >= 2 && k <= mem_lat);
            if (MEM_WRITE) begin
                wb_seen = 1'b1;
                wb_addr = MEM_ADDRESS;
                wb_data = MEM_WRITEDATA;
            end
            if (MEM_READ) begin
                rd_seen = 1'b1;
                rd_addr = MEM_ADDRESS;
            end
        end
    end

    task automatic do_reset();
        @(posedge CLK); #1;
        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    // Presents one access and returns, at a negedge, once BUSYWAIT is low.
    // stall counts the cycles BUSYWAIT stays high after the miss is registered.
    task automatic run_access(input logic rd, input logic wr, input logic [7:0] a,
                              input logic [7:0] wd, output int stall);
        @(posedge CLK); #1;
        READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
        @(negedge CLK);
        stall = 0;
        if (BUSYWAIT) begin
            @(negedge CLK);
            while (BUSYWAIT && stall < 100) begin
                stall++;
                @(negedge CLK);
            end
        end
    endtask

    typedef struct {
        bit          rst;
        bit          rd;
        bit          wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        int          lat;
        logic [31:0] fill;
        int          stall;
        logic [7:0]  rdata;
        bit          wb;
        logic [5:0]  wb_addr;
        logic [31:0] wb_data;
        bit          fetch;
        logic [5:0]  f_addr;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    initial begin
        int stall;
        int guard;

        //            rst rd wr addr   wdata  lat fill          stall rdata  wb wb_addr wb_data        fetch f_addr
        vecs[0]  = '{1, 1, 0, 8'h00, 8'h00, 5, 32'h44332211, 7,  8'h11, 0, 6'h00, 32'h00000000, 1, 6'h00};
        vecs[1]  = '{0, 1, 0, 8'h01, 8'h00, 5, 32'h00000000, 0,  8'h22, 0, 6'h00, 32'h00000000, 0, 6'h00};
        vecs[2]  = '{1, 0, 1, 8'h05, 8'hAB, 5, 32'hDDCCBBAA, 7,  8'h00, 0, 6'h00, 32'h00000000, 1, 6'h01};
        vecs[3]  = '{0, 1, 0, 8'h05, 8'h00, 5, 32'h00000000, 0,  8'hAB, 0, 6'h00, 32'h00000000, 0, 6'h00};
        vecs[4]  = '{0, 1, 0, 8'h04, 8'h00, 5, 32'h00000000, 0,  8'hAA, 0, 6'h00, 32'h00000000, 0, 6'h00};
        vecs[5]  = '{0, 1, 0, 8'h07, 8'h00, 5, 32'h00000000, 0,  8'hDD, 0, 6'h00, 32'h00000000, 0, 6'h00};
        vecs[6]  = '{0, 1, 0, 8'h25, 8'h00, 5, 32'h13579BDF, 13, 8'h9B, 1, 6'h01, 32'hDDCCABAA, 1, 6'h09};
        vecs[7]  = '{0, 1, 0, 8'h1C, 8'h00, 3, 32'h87654321, 5,  8'h21, 0, 6'h00, 32'h00000000, 1, 6'h07};
        vecs[8]  = '{0, 1, 0, 8'h00, 8'h00, 2, 32'h44332211, 4,  8'h11, 0, 6'h00, 32'h00000000, 1, 6'h00};
        vecs[9]  = '{0, 1, 0, 8'h1F, 8'h00, 2, 32'h00000000, 0,  8'h87, 0, 6'h00, 32'h00000000, 0, 6'h00};
        vecs[10] = '{0, 1, 0, 8'h03, 8'h00, 2, 32'h00000000, 0,  8'h44, 0, 6'h00, 32'h00000000, 0, 6'h00};
        vecs[11] = '{0, 0, 0, 8'h03, 8'h00, 2, 32'h00000000, 0,  8'h00, 0, 6'h00, 32'h00000000, 0, 6'h00};
        vecs[12] = '{0, 0, 1, 8'h02, 8'h5A, 2, 32'h00000000, 0,  8'h00, 0, 6'h00, 32'h00000000, 0, 6'h00};
        vecs[13] = '{0, 1, 0, 8'h02, 8'h00, 2, 32'h00000000, 0,  8'h5A, 0, 6'h00, 32'h00000000, 0, 6'h00};
        vecs[14] = '{0, 1, 0, 8'h22, 8'h00, 1, 32'hCAFEF00D, 5,  8'hFE, 1, 6'h00, 32'h445A2211, 1, 6'h08};
        vecs[15] = '{0, 1, 0, 8'h25, 8'h00, 1, 32'h00000000, 0,  8'h9B, 0, 6'h00, 32'h00000000, 0, 6'h00};
        vecs[16] = '{0, 1, 0, 8'h02, 8'h00, 1, 32'h0BADBEEF, 3,  8'hAD, 0, 6'h00, 32'h00000000, 1, 6'h00};

        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
        MEM_READDATA = '0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("reset BUSYWAIT",      BUSYWAIT,      0);
        chk("reset MEM_READ",      MEM_READ,      0);
        chk("reset MEM_WRITE",     MEM_WRITE,     0);
        chk("reset READDATA",      READDATA,      0);
        chk("reset MEM_ADDRESS",   MEM_ADDRESS,   0);
        chk("reset MEM_WRITEDATA", MEM_WRITEDATA, 0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rst) do_reset();
            mem_lat      = vecs[i].lat;
            MEM_READDATA = vecs[i].fill;
            wb_seen      = 1'b0;
            rd_seen      = 1'b0;
            run_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, stall);
            chk($sformatf("v%0d stall", i), stall, vecs[i].stall);
            chk($sformatf("v%0d busywait_done", i), BUSYWAIT, 0);
            if (!vecs[i].wr) chk($sformatf("v%0d readdata", i), READDATA, vecs[i].rdata);
            chk($sformatf("v%0d writeback_seen", i), wb_seen, vecs[i].wb);
            if (vecs[i].wb) begin
                chk($sformatf("v%0d wb_addr", i), wb_addr, vecs[i].wb_addr);
                chk($sformatf("v%0d wb_data", i), wb_data, vecs[i].wb_data);
            end
            chk($sformatf("v%0d fetch_seen", i), rd_seen, vecs[i].fetch);
            if (vecs[i].fetch) chk($sformatf("v%0d fetch_addr", i), rd_addr, vecs[i].f_addr);
        end

        // Reset in the middle of a fetch: request drops, line is not installed.
        do_reset();
        mem_lat      = 5;
        MEM_READDATA = 32'h11112222;
        @(posedge CLK); #1;
        READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h12;
        guard = 0;
        do begin
            @(negedge CLK);
            guard++;
        end while (!MEM_READ && guard < 20);
        chk("rst_mid fetch started", MEM_READ, 1);
        @(posedge CLK); #1;
        RESET = 1'b1; READ = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_mid MEM_READ",  MEM_READ,  0);
        chk("rst_mid MEM_WRITE", MEM_WRITE, 0);
        chk("rst_mid BUSYWAIT",  BUSYWAIT,  0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        MEM_READDATA = 32'h99887766;
        rd_seen = 1'b0;
        run_access(1'b1, 1'b0, 8'h12, 8'h00, stall);
        chk("rst_mid refetch stall", stall, 7);
        chk("rst_mid refetch data", READDATA, 8'h88);
        chk("rst_mid refetch seen", rd_seen, 1);
        chk("rst_mid refetch addr", rd_addr, 6'h04);

`ifdef DCACHE_STATS_EN
        do_reset();
        mem_lat      = 2;
        MEM_READDATA = 32'h01020304;
        run_access(1'b1, 1'b0, 8'h00, 8'h00, stall);
        run_access(1'b1, 1'b0, 8'h01, 8'h00, stall);
        run_access(1'b1, 1'b0, 8'h02, 8'h00, stall);
        MEM_READDATA = 32'h0A0B0C0D;
        run_access(1'b1, 1'b0, 8'h40, 8'h00, stall);
        chk("stats hit_count",  dut.hit_count,  2);
        chk("stats miss_count", dut.miss_count, 2);
`endif

        @(posedge CLK); #1;
        READ = 1'b0; WRITE = 1'b0;
        repeat (2) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
